poll_client: RTL

- Requester-side agent for the round-robin polling arbiter. One instance per arbiter channel (a/b/c).
- Buffers locally generated events, each with a payload, in a small FIFO.
- Drives the channel's request line while work is pending. Each arbiter trigger releases exactly one payload downstream.
- Monitors service latency and raises sticky error flags for protocol violations.

---
 rtl/poll_client_if.sv | 22 ++
 rtl/poll_client.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/poll_client_if.sv
// Channel bundle between an event source, the polling arbiter and one poll_client.
// Carries event push/data, the arbiter req/trg pair and the released payload.
interface poll_client_if #(
  parameter int DATA_W = 8
);
  logic              ev_push;
  logic [DATA_W-1:0] ev_data;
  logic              req;
  logic              trg;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output ev_push, ev_data, trg,
    input  req, out_valid, out_data
  );

  modport slave (
    input  ev_push, ev_data, trg,
    output req, out_valid, out_data
  );
endinterface

// File: rtl/poll_client.sv
// Requester agent for the round-robin polling arbiter: event FIFO, one pop per trg,
// req while occupied, service-latency watchdog and sticky protocol error flags.
// Ports: clk, rst (async active-low), bus (poll_client_if.slave: ev_push/ev_data in,
// req out, trg in, out_valid/out_data out), pending/full status, clr_err in,
// err_overflow/err_spurious/err_timeout sticky flags out.
module poll_client #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  poll_client_if.slave             bus,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     full,
  input  logic                     clr_err,
  output logic                     err_overflow,
  output logic                     err_spurious,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_WAIT  = 3'b010;
  localparam logic [2:0] S_STALL = 3'b100;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [PW-1:0]     r_cnt;
  logic [CW-1:0]     r_wait;
  logic [2:0]        r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_err_ov;
  logic              r_err_sp;
  logic              r_err_to;

  logic          w_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [PW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_wait_nxt;
  logic [2:0]    w_state_nxt;
  logic          w_ov_set;
  logic          w_sp_set;
  logic          w_to_set;

  assign w_req  = (r_cnt != '0);
  assign w_full = (r_cnt == PW'(DEPTH));
  assign w_pop  = bus.trg & w_req;
  // a pop frees the head slot this cycle, so a full FIFO can still accept
  assign w_push = bus.ev_push & (~w_full | w_pop);

  assign w_ov_set = bus.ev_push & w_full & ~w_pop;
  assign w_sp_set = bus.trg & ~w_req;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + PW'(1);
      2'b01:   w_cnt_nxt = r_cnt - PW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // IDLE leaves on the same edge the first entry lands, so the watchdog
  // counts every cycle req is high
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_to_set    = 1'b0;
    unique case (1'b1)
      r_state[0]: begin
        w_wait_nxt = '0;
        if (w_cnt_nxt != '0)
          w_state_nxt = S_WAIT;
      end
      r_state[1]: begin
        if (w_pop) begin
          w_wait_nxt  = '0;
          w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
        end else if (w_req) begin
          w_wait_nxt = r_wait + CW'(1);
          if (r_wait == CW'(TIMEOUT - 1)) begin
            w_to_set    = 1'b1;
            w_state_nxt = S_STALL;
          end
        end
      end
      r_state[2]: begin
        if (w_pop) begin
          w_wait_nxt  = '0;
          w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
        end
      end
      default: begin
        w_wait_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= bus.ev_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_state     <= w_state_nxt;
      r_out_valid <= w_pop;
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd       <= r_rd + AW'(1);
        r_out_data <= r_mem[r_rd];
      end
    end
  end

  // a new error event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_ov <= 1'b0;
      r_err_sp <= 1'b0;
      r_err_to <= 1'b0;
    end else begin
      r_err_ov <= (r_err_ov & ~clr_err) | w_ov_set;
      r_err_sp <= (r_err_sp & ~clr_err) | w_sp_set;
      r_err_to <= (r_err_to & ~clr_err) | w_to_set;
    end
  end

  assign bus.req       = w_req;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign pending       = r_cnt;
  assign full          = w_full;
  assign err_overflow  = r_err_ov;
  assign err_spurious  = r_err_sp;
  assign err_timeout   = r_err_to;

endmodule
